// File: rtl/gpio_pkg.sv
// Shared constants for the board-side GPIO block: word widths, digit count
// and the active-low seven-segment glyph table {g,f,e,d,c,b,a}.
package gpio_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int GPIO_W     = 32;

    // Entry n is the glyph for hex digit n (index 15 is listed first).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/gpio_board_io_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
import gpio_pkg::*;

module hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/gpio_board_io.sv
// Board-side GPIO: switch synchronizer/debouncer into gpio_in, and gpio_out
// shown on a multiplexed 8-digit display. Define GPIO_DEBOUNCE_EN to debounce.
import gpio_pkg::*;

module gpio_board_io #(
    parameter int SW_WIDTH        = 18,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SCAN_DIV        = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW_WIDTH-1:0]   sw,
    input  logic [GPIO_W-1:0]     gpio_out,
    output logic [GPIO_W-1:0]     gpio_in,
    output logic                  out_upd,
    output logic [NUM_DIGITS-1:0] hex_an,
    output logic [6:0]            hex_seg
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(SCAN_DIV - 1);

    logic [SW_WIDTH-1:0] sync1, sync2, stable;
    logic [GPIO_W-1:0]   disp_reg;
    logic [PS_W-1:0]     prescaler;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          nib;
    logic [6:0]          seg;

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] cand;
    logic [CNT_W-1:0]    cnt;

    // Any change anywhere in the vector restarts the count for all bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            stable <= '0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= cand;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
        end else begin
            sync1  <= sw;
            sync2  <= sync1;
            stable <= sync2;
        end
    end
`endif

    assign gpio_in = GPIO_W'(stable);

    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_reg <= '0;
            out_upd  <= 1'b0;
        end else begin
            disp_reg <= gpio_out;
            out_upd  <= (gpio_out != disp_reg);
        end
    end

    assign nib = disp_reg[4*idx +: 4];

    hex7seg u_hex7seg (
        .nibble (nib),
        .seg    (seg)
    );

    // Outputs are registered from the current idx, so a digit change shows
    // one edge after the prescaler wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prescaler <= '0;
            idx       <= '0;
            hex_an    <= '1;
            hex_seg   <= '1;
        end else begin
            if (prescaler == PS_MAX) begin
                prescaler <= '0;
                idx       <= idx + IDX_W'(1);
            end else begin
                prescaler <= prescaler + PS_W'(1);
            end
            hex_an  <= ~(NUM_DIGITS'(1) << idx);
            hex_seg <= seg;
        end
    end

endmodule

// File: tb/tb_gpio_board_io.sv
// Self-checking bench for gpio_board_io: directed plan steps followed by random
// traffic, every cycle compared against a behavioural model.
module tb_gpio_board_io;

    localparam int SW_W = 18;
    localparam int DC   = 4;
    localparam int SD   = 3;
`ifdef GPIO_DEBOUNCE_EN
    localparam int N_LAT = DC + 2;
`else
    localparam int N_LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [SW_W-1:0] sw;
    logic [31:0]     gpio_out;
    logic [31:0]     gpio_in;
    logic            out_upd;
    logic [7:0]      hex_an;
    logic [6:0]      hex_seg;

    always #5 clk = ~clk;

    gpio_board_io #(
        .SW_WIDTH        (SW_W),
        .DEBOUNCE_CYCLES (DC),
        .SCAN_DIV        (SD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .out_upd  (out_upd),
        .hex_an   (hex_an),
        .hex_seg  (hex_seg)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: recent switch samples, edges since reset, the current run
    // of identical synchronized values, and the word the display holds.
    logic [SW_W-1:0] sw_q [$];
    int              rst_age = 1000;
    logic [SW_W-1:0] run_val;
    int              run_len;
    logic [SW_W-1:0] exp_stable;
    logic [31:0]     m_disp;
    int              upd_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic            r;
        logic [SW_W-1:0] s;
        logic [31:0]     g;
        logic [SW_W-1:0] h;
        int              dig;
        logic [3:0]      nibv;
        logic            exp_upd;
        logic [7:0]      exp_an;
        logic [6:0]      exp_seg;
        r = rst;
        s = sw;
        g = gpio_out;
        @(posedge clk);
        sw_q.push_back(s);
        if (sw_q.size() > 3) void'(sw_q.pop_front());
        if (!r) begin
            rst_age    = 0;
            run_val    = '0;
            run_len    = 1;
            exp_stable = '0;
            exp_upd    = 1'b0;
            exp_an     = 8'hFF;
            exp_seg    = 7'h7F;
            m_disp     = '0;
        end else begin
            if (rst_age < 1000000) rst_age++;
            // A switch sample reaches the conditioner two edges after capture.
            h = (rst_age >= 3) ? sw_q[0] : '0;
`ifdef GPIO_DEBOUNCE_EN
            if (h == run_val) begin
                if (run_len <= DC) run_len++;
            end else begin
                run_val = h;
                run_len = 1;
            end
            if (run_len >= DC + 1) exp_stable = run_val;
`else
            exp_stable = h;
`endif
            dig     = ((rst_age - 1) / SD) % 8;
            exp_an  = ~(8'b1 << dig);
            nibv    = m_disp[4*dig +: 4];
            exp_seg = seg_ref[nibv];
            exp_upd = (g != m_disp);
            m_disp  = g;
        end
        #1;
        check("gpio_in", gpio_in, {14'b0, exp_stable});
        check("out_upd", {31'b0, out_upd}, {31'b0, exp_upd});
        check("hex_an", {24'b0, hex_an}, {24'b0, exp_an});
        check("hex_seg", {25'b0, hex_seg}, {25'b0, exp_seg});
        if (out_upd === 1'b1) upd_count++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    logic [7:0] an_dir  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] seg_dir [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

    initial begin
        // 1: reset with all switches high
        rst = 1'b0; sw = '1; gpio_out = '0;
        steps(2);
        check("rst_gpio_in", gpio_in, 32'h0);
        check("rst_hex_an", {24'b0, hex_an}, 32'hFF);
        check("rst_hex_seg", {25'b0, hex_seg}, 32'h7F);
        check("rst_out_upd", {31'b0, out_upd}, 32'h0);
        rst = 1'b1; sw = '0;
        steps(10);

        // 2: clean step to 5
        sw = 18'h00005;
        step();
        for (int j = 1; j < N_LAT; j++) begin
            step();
            check("step_early", gpio_in, 32'h0);
        end
        step();
        check("step_late", gpio_in, 32'h5);

        // 3: bounce on bit 0, then hold 1
        sw = '0;
        steps(10);
        for (int i = 0; i < 4; i++) begin
            sw[0] = ~sw[0];
            steps(2);
`ifdef GPIO_DEBOUNCE_EN
            check("bounce_quiet", gpio_in, 32'h0);
`endif
        end
        sw[0] = ~sw[0];
        step();
        for (int j = 1; j < N_LAT; j++) begin
            step();
            check("bounce_hold", gpio_in, 32'h0);
        end
        step();
        check("bounce_accept", gpio_in, 32'h1);

        // 4: full scan of 89ABCDEF from a fresh reset
        rst = 1'b0; gpio_out = 32'h89ABCDEF;
        step();
        rst = 1'b1; upd_count = 0;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < SD; c++) begin
                step();
                if (d != 0 || c != 0) begin
                    check("scan_an", {24'b0, hex_an}, {24'b0, an_dir[d]});
                    check("scan_seg", {25'b0, hex_seg}, {25'b0, seg_dir[d]});
                end
            end
        end
        check("scan_upd_once", upd_count, 32'd1);

        // 5: reset while a debounce is in progress
        sw = '0;
        steps(10);
        sw = 18'h2A5A5;
        steps(5);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst_gpio_in", gpio_in, 32'h0);
        for (int j = 1; j <= N_LAT; j++) begin
            step();
            check("midrst_hold", gpio_in, 32'h0);
        end
        step();
        check("midrst_accept", gpio_in, 32'h2A5A5);

        // 6: held output word, then a single change
        gpio_out = 32'h12345678;
        steps(2);
        upd_count = 0;
        steps(20);
        check("hold_no_upd", upd_count, 32'd0);
        gpio_out = 32'hCAFEF00D;
        step();
        check("change_upd", {31'b0, out_upd}, 32'h1);
        steps(5);
        check("change_upd_once", upd_count, 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) sw = SW_W'($urandom);
            if ($urandom_range(0, 4) == 0) gpio_out = $urandom;
            rst = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
